// File: rtl/keypad_scan_fifo_pkg.sv
// Shared types and helpers for the keypad scanner: debounce FSM states and
// the key-code width function.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} kp_state_t;

  function automatic int key_w(input int nr, input int nc);
    return $clog2(nr * nc);
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_if.sv
// MCU-side key queue port of the keypad scanner.
// key_valid/key_ack: the head code transfers on every clock where both are
// high; key_ack while key_valid is low is ignored; key_code holds the head
// entry and stays stable while key_valid is high until it is acked.
interface keypad_scan_fifo_if #(
  parameter int KEY_W = 4,
  parameter int CNT_W = 3
);
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ack;
  logic             intr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clr_ovf;

  modport master (
    output key_code, key_valid, intr, count, overflow,
    input  key_ack, clr_ovf
  );

  modport slave (
    input  key_code, key_valid, intr, count, overflow,
    output key_ack, clr_ovf
  );
endinterface

// File: rtl/keypad_scan_fifo_key_fifo.sv
// Show-ahead synchronous FIFO for key codes; a push into a full FIFO is only
// accepted when a pop happens in the same clock.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: one-hot row drive, synchronised column sampling,
// per-frame ghost rejection and debounce, key codes queued for the MCU.
module keypad_scan_fifo
  import keypad_pkg::*;
#(
  parameter int NROWS      = 4,
  parameter int NCOLS      = 3,
  parameter int SCAN_DIV   = 2,
  parameter int DEBOUNCE   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCOLS-1:0]   cols,
  output logic [NROWS-1:0]   rows,
  keypad_scan_fifo_if.master kp,
  output kp_state_t          state_o
);
  localparam int NKEYS = NROWS * NCOLS;
  localparam int KEY_W = key_w(NROWS, NCOLS);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RW    = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int CW    = $clog2(DEBOUNCE + 1);
  localparam logic [NROWS-1:0] ROW0 = NROWS'(1);

  logic [NCOLS-1:0] cols_s1_q, cols_s2_q;
  logic [DW-1:0]    div_q;
  logic [RW-1:0]    row_q, smp_row1_q, smp_row2_q;
  logic [1:0]       smp_q;
  logic [NKEYS-1:0] acc_q, frame_bits;
  logic             scan_last, frame_eval, frame_seen, frame_multi;
  logic [KEY_W-1:0] frame_code, cand_q;
  logic [CW-1:0]    cnt_q;
  kp_state_t        state_q;
  logic             push_q, intr_q, ovf_q;
  logic             fifo_full, fifo_empty, pop_ok;
  logic [KEY_W-1:0] fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  assign scan_last = (div_q == DW'(SCAN_DIV - 1));
  assign rows      = ROW0 << row_q;

  // The row strobe and index ride a two-stage pipeline matching the column
  // synchroniser, so each sample lands in the slot of the row that produced it.
  assign frame_eval = smp_q[1] && (smp_row2_q == RW'(NROWS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols_s1_q  <= '0;
      cols_s2_q  <= '0;
      div_q      <= '0;
      row_q      <= '0;
      smp_q      <= '0;
      smp_row1_q <= '0;
      smp_row2_q <= '0;
      acc_q      <= '0;
    end else begin
      cols_s1_q  <= cols;
      cols_s2_q  <= cols_s1_q;
      div_q      <= scan_last ? '0 : div_q + DW'(1);
      if (scan_last) row_q <= (row_q == RW'(NROWS - 1)) ? '0 : row_q + RW'(1);
      smp_q      <= {smp_q[0], scan_last};
      smp_row1_q <= row_q;
      smp_row2_q <= smp_row1_q;
      if (smp_q[1]) acc_q[int'(smp_row2_q)*NCOLS +: NCOLS] <= cols_s2_q;
    end
  end

  always_comb begin
    frame_bits = acc_q;
    frame_bits[int'(smp_row2_q)*NCOLS +: NCOLS] = cols_s2_q;
    frame_seen  = 1'b0;
    frame_multi = 1'b0;
    frame_code  = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (frame_bits[i]) begin
        frame_multi = frame_multi | frame_seen;
        frame_seen  = 1'b1;
        frame_code  = KEY_W'(i);
      end
    end
  end

  // Ghost frames never reach the FSM, so they hold both state and counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (frame_eval && !frame_multi) begin
        case (state_q)
          IDLE: if (frame_seen) begin
            cand_q <= frame_code;
            cnt_q  <= CW'(1);
            if (DEBOUNCE == 1) begin
              push_q  <= 1'b1;
              state_q <= HELD;
            end else begin
              state_q <= PRESS_CHK;
            end
          end
          PRESS_CHK: begin
            if (!frame_seen) begin
              state_q <= IDLE;
            end else if (frame_code != cand_q) begin
              cand_q <= frame_code;
              cnt_q  <= CW'(1);
            end else if (cnt_q + CW'(1) == CW'(DEBOUNCE)) begin
              push_q  <= 1'b1;
              state_q <= HELD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          HELD: if (!frame_seen) begin
            cnt_q   <= CW'(1);
            state_q <= (DEBOUNCE == 1) ? IDLE : REL_CHK;
          end
          REL_CHK: begin
            if (frame_seen) begin
              state_q <= HELD;
            end else if (cnt_q + CW'(1) == CW'(DEBOUNCE)) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign pop_ok = kp.key_ack & ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      intr_q <= push_q & (~fifo_full | pop_ok);
      if (push_q & fifo_full & ~pop_ok) ovf_q <= 1'b1;
      else if (kp.clr_ovf)              ovf_q <= 1'b0;
    end
  end

  key_fifo #(.WIDTH(KEY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .pop_i   (kp.key_ack),
    .din_i   (cand_q),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign kp.key_code  = fifo_dout;
  assign kp.key_valid = ~fifo_empty;
  assign kp.count     = fifo_count;
  assign kp.intr      = intr_q;
  assign kp.overflow  = ovf_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Bench for keypad_scan_fifo: scripted key scenarios plus randomized frame
// sequences scored against a frame-level debounce model.
`timescale 1ns/1ps
module tb_keypad_scan_fifo;
  import keypad_pkg::*;

  localparam int NROWS = 4, NCOLS = 3, SCAN_DIV = 2, DEBOUNCE = 2, FIFO_DEPTH = 4;
  localparam int NKEYS = NROWS * NCOLS;
  localparam int KEY_W = 4, CNT_W = 3;
  localparam int FRAME = NROWS * SCAN_DIV;
  localparam int PUSH_OFS = 2; // negedges from frame start to the FIFO push clock

  logic clk = 1'b0;
  logic reset;
  logic [NCOLS-1:0] cols;
  logic [NROWS-1:0] rows;
  kp_state_t        state_dbg;
  logic [NKEYS-1:0] keys_down;
  int checks = 0, errors = 0, intr_seen = 0;
  logic [KEY_W-1:0] exp_q[$];

  // frame-level reference model state
  bit m_armed;
  int m_run, m_quiet, m_pushes;
  logic [KEY_W-1:0] m_code;

  keypad_scan_fifo_if #(.KEY_W(KEY_W), .CNT_W(CNT_W)) kp();

  keypad_scan_fifo #(
    .NROWS(NROWS), .NCOLS(NCOLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows),
    .kp(kp.master), .state_o(state_dbg)
  );

  // ---------------- clock / key matrix ----------------
  always #5 clk = ~clk;

  always_comb begin
    cols = '0;
    for (int r = 0; r < NROWS; r++)
      if (rows[r]) cols = cols | keys_down[r*NCOLS +: NCOLS];
  end

  always @(negedge clk) if (kp.intr === 1'b1) intr_seen++;

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    keys_down = '0;
    kp.key_ack = 1'b0;
    kp.clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic next_frame();
    int n = 0;
    while (rows === ROW0() && n < 2*FRAME) begin @(negedge clk); n++; end
    while (rows !== ROW0() && n < 4*FRAME) begin @(negedge clk); n++; end
    if (rows !== ROW0()) begin
      checks++; errors++;
      $display("FAIL frame_timeout rows=%b exp=%b", rows, ROW0());
    end
  endtask

  function automatic logic [NROWS-1:0] ROW0();
    logic [NROWS-1:0] r = '0;
    r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [NKEYS-1:0] key_bit(input int code);
    logic [NKEYS-1:0] k = '0;
    k[code] = 1'b1;
    return k;
  endfunction

  task automatic frame(input logic [NKEYS-1:0] k);
    keys_down = k;
    next_frame();
  endtask

  task automatic press_key(input int code);
    frame(key_bit(code));
    frame(key_bit(code));
    frame('0);
    frame('0);
  endtask

  // Accepts a key once DEBOUNCE consecutive single-key frames agree while
  // released; a release needs DEBOUNCE consecutive empty frames.
  task automatic model_frame(input logic [NKEYS-1:0] k);
    int n = $countones(k);
    logic [KEY_W-1:0] c = '0;
    for (int i = 0; i < NKEYS; i++) if (k[i]) c = KEY_W'(i);
    if (n > 1) return;
    if (m_armed) begin
      if (n == 0) m_run = 0;
      else begin
        if (m_run > 0 && c == m_code) m_run++;
        else begin m_code = c; m_run = 1; end
        if (m_run == DEBOUNCE) begin
          exp_q.push_back(c); m_pushes++; m_armed = 0; m_quiet = 0;
        end
      end
    end else begin
      if (n == 0) begin
        m_quiet++;
        if (m_quiet == DEBOUNCE) begin m_armed = 1; m_run = 0; end
      end else m_quiet = 0;
    end
  endtask

  task automatic drain(input string tag);
    logic [KEY_W-1:0] e;
    for (int n = 0; n < 2*FIFO_DEPTH && kp.key_valid === 1'b1; n++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL %s_extra got=%0d exp=none", tag, kp.key_code);
      end else begin
        e = exp_q.pop_front();
        if (kp.key_code !== e) begin
          errors++; $display("FAIL %s_code got=%0d exp=%0d", tag, kp.key_code, e);
        end
      end
      kp.key_ack = 1'b1;
      @(negedge clk);
      kp.key_ack = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [NROWS-1:0] er;
    do_reset();
    frame(key_bit(5));
    frame(key_bit(5));
    repeat (4) @(negedge clk);
    checks++;
    if (kp.count !== 3'd1) begin errors++; $display("FAIL pre_reset_count got=%0d exp=1", kp.count); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rows !== 4'b0001 || kp.key_valid !== 1'b0 || kp.key_code !== 4'd0 ||
        kp.intr !== 1'b0 || kp.count !== 3'd0 || kp.overflow !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL async_reset rows=%b valid=%b code=%0d intr=%b count=%0d ovf=%b st=%0d exp 0001/0/0/0/0/0/0",
               rows, kp.key_valid, kp.key_code, kp.intr, kp.count, kp.overflow, state_dbg);
    end
    keys_down = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      er = ROW0() << (i / SCAN_DIV);
      checks++;
      if (rows !== er) begin errors++; $display("FAIL row_seq_%0d got=%b exp=%b", i, rows, er); end
    end
  endtask

  task automatic test_single_press();
    int i0;
    do_reset();
    i0 = intr_seen;
    keys_down = key_bit(3);
    next_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (kp.count !== 3'd0) begin errors++; $display("FAIL single_early got=%0d exp=0", kp.count); end
    next_frame();
    repeat (4) @(negedge clk);
    checks++;
    if (kp.key_valid !== 1'b1 || kp.key_code !== 4'd3 || kp.count !== 3'd1) begin
      errors++; $display("FAIL single_push valid=%b code=%0d count=%0d exp 1/3/1", kp.key_valid, kp.key_code, kp.count);
    end
    next_frame();
    frame('0); frame('0); frame('0);
    checks++;
    if (intr_seen - i0 !== 1 || kp.count !== 3'd1) begin
      errors++; $display("FAIL single_once intr=%0d count=%0d exp 1/1", intr_seen - i0, kp.count);
    end
  endtask

  task automatic test_bounce();
    int i0;
    do_reset();
    i0 = intr_seen;
    frame(key_bit(7)); frame('0); frame(key_bit(7)); frame('0); frame('0);
    checks++;
    if (intr_seen - i0 !== 0 || kp.count !== 3'd0) begin
      errors++; $display("FAIL bounce_nopush intr=%0d count=%0d exp 0/0", intr_seen - i0, kp.count);
    end
    frame(key_bit(7)); frame(key_bit(7)); frame('0); frame('0);
    checks++;
    if (intr_seen - i0 !== 1 || kp.key_code !== 4'd7 || kp.count !== 3'd1) begin
      errors++; $display("FAIL bounce_push intr=%0d code=%0d count=%0d exp 1/7/1", intr_seen - i0, kp.key_code, kp.count);
    end
  endtask

  task automatic test_ghost();
    int i0;
    do_reset();
    i0 = intr_seen;
    keys_down = key_bit(3) | key_bit(4);
    for (int f = 0; f < 4; f++) begin
      next_frame();
      repeat (3) @(negedge clk);
      checks++;
      if (state_dbg !== IDLE) begin errors++; $display("FAIL ghost_state_%0d got=%0d exp=%0d", f, state_dbg, IDLE); end
    end
    next_frame();
    checks++;
    if (intr_seen - i0 !== 0 || kp.count !== 3'd0) begin
      errors++; $display("FAIL ghost_nopush intr=%0d count=%0d exp 0/0", intr_seen - i0, kp.count);
    end
  endtask

  task automatic test_overflow();
    int i0;
    int codes[4] = '{0, 4, 8, 11};
    do_reset();
    exp_q.delete();
    i0 = intr_seen;
    for (int i = 0; i < 4; i++) begin press_key(codes[i]); exp_q.push_back(KEY_W'(codes[i])); end
    checks++;
    if (kp.count !== 3'd4 || kp.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_fill count=%0d ovf=%b exp 4/0", kp.count, kp.overflow);
    end
    frame(key_bit(1));
    frame(key_bit(1));
    keys_down = '0;
    repeat (PUSH_OFS) @(negedge clk);
    kp.clr_ovf = 1'b1;
    @(negedge clk);
    kp.clr_ovf = 1'b0;
    checks++;
    if (kp.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got=%b exp=1", kp.overflow); end
    next_frame(); frame('0);
    checks++;
    if (kp.count !== 3'd4 || kp.overflow !== 1'b1 || intr_seen - i0 !== 4 || kp.key_code !== 4'd0) begin
      errors++; $display("FAIL ovf_drop count=%0d ovf=%b intr=%0d head=%0d exp 4/1/4/0",
                         kp.count, kp.overflow, intr_seen - i0, kp.key_code);
    end
    kp.clr_ovf = 1'b1;
    @(negedge clk);
    kp.clr_ovf = 1'b0;
    checks++;
    if (kp.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", kp.overflow); end
    drain("ovf");
    checks++;
    if (kp.key_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL ovf_empty valid=%b left=%0d exp 0/0", kp.key_valid, exp_q.size());
    end
  endtask

  task automatic test_full_ack();
    int i0;
    int codes[4] = '{1, 2, 5, 6};
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) press_key(codes[i]);
    for (int i = 1; i < 4; i++) exp_q.push_back(KEY_W'(codes[i]));
    exp_q.push_back(KEY_W'(9));
    i0 = intr_seen;
    frame(key_bit(9));
    frame(key_bit(9));
    keys_down = '0;
    repeat (PUSH_OFS) @(negedge clk);
    kp.key_ack = 1'b1;
    @(negedge clk);
    kp.key_ack = 1'b0;
    checks++;
    if (kp.intr !== 1'b1 || kp.count !== 3'd4 || kp.overflow !== 1'b0) begin
      errors++; $display("FAIL full_ack intr=%b count=%0d ovf=%b exp 1/4/0", kp.intr, kp.count, kp.overflow);
    end
    next_frame(); frame('0);
    checks++;
    if (intr_seen - i0 !== 1) begin errors++; $display("FAIL full_ack_intr got=%0d exp=1", intr_seen - i0); end
    drain("full");
    checks++;
    if (kp.key_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL full_empty valid=%b left=%0d exp 0/0", kp.key_valid, exp_q.size());
    end
  endtask

  task automatic test_random_frames();
    int i0, r, a, b;
    logic [KEY_W-1:0] pool[3];
    logic [NKEYS-1:0] k;
    do_reset();
    exp_q.delete();
    m_armed = 1; m_run = 0; m_quiet = 0; m_pushes = 0; m_code = '0;
    i0 = intr_seen;
    for (int i = 0; i < 3; i++) pool[i] = KEY_W'($urandom_range(0, NKEYS-1));
    for (int f = 0; f < 80; f++) begin
      r = $urandom_range(0, 99);
      if (r < 40) k = '0;
      else if (r < 85) k = key_bit(int'(pool[$urandom_range(0, 2)]));
      else begin
        a = $urandom_range(0, NKEYS-1);
        b = (a + 1 + $urandom_range(0, NKEYS-2)) % NKEYS;
        k = key_bit(a) | key_bit(b);
      end
      model_frame(k);
      keys_down = k;
      drain("rand");
      next_frame();
    end
    frame('0); frame('0);
    drain("rand");
    checks++;
    if (exp_q.size() != 0 || intr_seen - i0 !== m_pushes || kp.overflow !== 1'b0) begin
      errors++; $display("FAIL rand_end left=%0d intr=%0d exp_intr=%0d ovf=%b exp_ovf=0",
                         exp_q.size(), intr_seen - i0, m_pushes, kp.overflow);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    keys_down = '0;
    kp.key_ack = 1'b0;
    kp.clr_ovf = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overflow();
    test_full_ack();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
